// File: rtl/jtag_scan_master.sv
// JTAG scan initiator: walks the TAP through one IR/DR scan per command and returns the captured TDO bits.
// Optional RUNTEST_IDLE_EN adds cmd_idle: extra Run-Test/Idle TCKs after Update, before the response.
module jtag_scan_master #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               CK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_tdi,
`ifdef RUNTEST_IDLE_EN
  input  logic [7:0]         cmd_idle,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_tdo,
  output logic               rsp_err,
  output logic               busy,
  output logic               TCLK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int unsigned PH_W    = $clog2(2 * CLK_DIV);
  localparam int unsigned PH_LAST = 2 * CLK_DIV - 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TLR_LAST = 5;

  // Each state names the TAP state the CUT is in during the current TCK.
  typedef enum logic [3:0] {
    S_TLR,
    S_IDLE,
    S_RESP,
    S_RTI_GO,
    S_SEL_DR,
    S_SEL_IR,
    S_CAPTURE,
    S_SHIFT,
    S_EXIT1,
    S_UPDATE,
    S_RUNTEST
  } state_t;

  state_t             state_q, state_n;
  logic [PH_W-1:0]    ph_q, ph_n;
  logic               tclk_q, tclk_n;
  logic               tms_q, tms_n;
  logic               tdi_q, tdi_n;
  logic               cmd_ready_q, cmd_ready_n;
  logic               rsp_valid_q, rsp_valid_n;
  logic               rsp_err_q, rsp_err_n;
  logic [MAX_LEN-1:0] rsp_tdo_q, rsp_tdo_n;
  logic               busy_q, busy_n;
  logic               ir_q, ir_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   bit_q, bit_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [MAX_LEN-1:0] tdi_sh_q, tdi_sh_n;
  logic [MAX_LEN-1:0] tdo_sh_q, tdo_sh_n;
`ifdef RUNTEST_IDLE_EN
  logic [7:0]         idle_q, idle_n;
`endif

  logic tap_run;
  logic tick_end;
  logic rise;
  logic done;
  logic bad_len;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign busy      = busy_q;
  assign TCLK      = tclk_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  // Next-state and output logic; TMS/TDI only change on a TCK-starting edge.
  always_comb begin
    state_n     = state_q;
    ph_n        = '0;
    tclk_n      = 1'b0;
    tms_n       = tms_q;
    tdi_n       = tdi_q;
    cmd_ready_n = cmd_ready_q;
    rsp_valid_n = rsp_valid_q;
    rsp_err_n   = rsp_err_q;
    rsp_tdo_n   = rsp_tdo_q;
    busy_n      = busy_q;
    ir_n        = ir_q;
    len_n       = len_q;
    bit_n       = bit_q;
    cnt_n       = cnt_q;
    tdi_sh_n    = tdi_sh_q;
    tdo_sh_n    = tdo_sh_q;
`ifdef RUNTEST_IDLE_EN
    idle_n      = idle_q;
`endif
    done        = 1'b0;

    tap_run  = (state_q != S_IDLE) && (state_q != S_RESP);
    tick_end = (ph_q == PH_W'(PH_LAST));
    rise     = (ph_q == PH_W'(CLK_DIV - 1));
    bad_len  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));

    if (tap_run) begin
      ph_n = tick_end ? '0 : ph_q + PH_W'(1);
    end

    // TDO enters at the top so the first sample ends up at bit 0 after alignment.
    if (rise && (state_q == S_SHIFT)) begin
      tdo_sh_n = {TDO, tdo_sh_q[MAX_LEN-1:1]};
    end

    case (state_q)
      S_TLR: begin
        if (tick_end) begin
          if (cnt_q == CNT_W'(TLR_LAST)) begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            tms_n       = 1'b0;
            busy_n      = 1'b0;
            cmd_ready_n = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
            tms_n = (cnt_q < CNT_W'(TLR_LAST - 1));
          end
        end
      end
      S_IDLE: begin
        tms_n = 1'b0;
        tdi_n = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_n = 1'b0;
          ir_n        = cmd_ir;
          len_n       = cmd_len;
          tdi_sh_n    = cmd_tdi;
          tdo_sh_n    = '0;
          bit_n       = cmd_len - LEN_W'(1);
`ifdef RUNTEST_IDLE_EN
          idle_n      = cmd_idle;
`endif
          if (bad_len) begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_tdo_n   = '0;
          end else begin
            state_n = S_RTI_GO;
            tms_n   = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      S_RTI_GO: begin
        if (tick_end) begin
          state_n = S_SEL_DR;
          tms_n   = ir_q;
        end
      end
      S_SEL_DR: begin
        if (tick_end) begin
          state_n = ir_q ? S_SEL_IR : S_CAPTURE;
          tms_n   = 1'b0;
        end
      end
      S_SEL_IR: begin
        if (tick_end) begin
          state_n = S_CAPTURE;
          tms_n   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (tick_end) begin
          state_n  = S_SHIFT;
          tms_n    = (bit_q == '0);
          tdi_n    = tdi_sh_q[0];
          tdi_sh_n = tdi_sh_q >> 1;
        end
      end
      S_SHIFT: begin
        if (tick_end) begin
          if (bit_q == '0) begin
            state_n = S_EXIT1;
            tms_n   = 1'b1;
            tdi_n   = 1'b0;
          end else begin
            bit_n    = bit_q - LEN_W'(1);
            tms_n    = (bit_q == LEN_W'(1));
            tdi_n    = tdi_sh_q[0];
            tdi_sh_n = tdi_sh_q >> 1;
          end
        end
      end
      S_EXIT1: begin
        if (tick_end) begin
          state_n = S_UPDATE;
          tms_n   = 1'b0;
        end
      end
      S_UPDATE: begin
        if (tick_end) begin
`ifdef RUNTEST_IDLE_EN
          if (idle_q != '0) begin
            state_n = S_RUNTEST;
            tms_n   = 1'b0;
            cnt_n   = CNT_W'(idle_q - 8'd1);
          end else begin
            done = 1'b1;
          end
`else
          done = 1'b1;
`endif
        end
      end
      S_RUNTEST: begin
        if (tick_end) begin
          if (cnt_q == '0) begin
            done = 1'b1;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
          rsp_err_n   = 1'b0;
          rsp_tdo_n   = '0;
          cmd_ready_n = 1'b1;
        end
      end
      default: begin
        state_n = S_TLR;
      end
    endcase

    if (done) begin
      state_n     = S_RESP;
      rsp_valid_n = 1'b1;
      rsp_err_n   = 1'b0;
      rsp_tdo_n   = tdo_sh_q >> (LEN_W'(MAX_LEN) - len_q);
      busy_n      = 1'b0;
      tms_n       = 1'b0;
      tdi_n       = 1'b0;
      cnt_n       = '0;
      ph_n        = '0;
    end

    tclk_n = (ph_n >= PH_W'(CLK_DIV));
  end

  // State register; TRST aborts any scan and restarts the TLR walk.
  always_ff @(posedge CK) begin
    if (TRST) begin
      state_q     <= S_TLR;
      ph_q        <= '0;
      tclk_q      <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tdo_q   <= '0;
      busy_q      <= 1'b1;
      ir_q        <= 1'b0;
      len_q       <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      tdi_sh_q    <= '0;
      tdo_sh_q    <= '0;
`ifdef RUNTEST_IDLE_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_n;
      ph_q        <= ph_n;
      tclk_q      <= tclk_n;
      tms_q       <= tms_n;
      tdi_q       <= tdi_n;
      cmd_ready_q <= cmd_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_err_q   <= rsp_err_n;
      rsp_tdo_q   <= rsp_tdo_n;
      busy_q      <= busy_n;
      ir_q        <= ir_n;
      len_q       <= len_n;
      bit_q       <= bit_n;
      cnt_q       <= cnt_n;
      tdi_sh_q    <= tdi_sh_n;
      tdo_sh_q    <= tdo_sh_n;
`ifdef RUNTEST_IDLE_EN
      idle_q      <= idle_n;
`endif
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: logs TAP pins per TCK and checks each scan against TAP-sequence rules.
module tb_jtag_scan_master;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned CLK_DIV = 2;

  logic               CK = 1'b0;
  logic               TRST = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_tdi = '0;
`ifdef RUNTEST_IDLE_EN
  logic [7:0]         cmd_idle = '0;
`endif
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_tdo;
  logic               rsp_err;
  logic               busy;
  logic               TCLK;
  logic               TMS;
  logic               TDI;
  logic               TDO = 1'b0;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .CK(CK), .TRST(TRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
`ifdef RUNTEST_IDLE_EN
    .cmd_idle(cmd_idle),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
    .rsp_err(rsp_err), .busy(busy),
    .TCLK(TCLK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  logic tms_log[$];
  logic tdi_log[$];
  logic tdo_log[$];
  logic last_tdi = 1'b0;
  int   tdo_mode = 0;  // 0 random, 1 tied high, 2 one-TCK TDI loopback

  // Pin log: one entry per rising TCLK.
  always @(posedge TCLK) begin
    #1;
    tms_log.push_back(TMS);
    tdi_log.push_back(TDI);
    tdo_log.push_back(TDO);
    last_tdi = TDI;
  end

  // CUT model: TDO changes on falling TCLK.
  always @(negedge TCLK) begin
    case (tdo_mode)
      0:       TDO = 1'($urandom_range(0, 1));
      1:       TDO = 1'b1;
      default: TDO = last_tdi;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic q[$]);
    logic [127:0] v = '0;
    for (int k = 0; k < q.size() && k < 128; k++) v[k] = q[k];
    return v;
  endfunction

  function automatic logic [63:0] len_mask(input int len);
    logic [63:0] one = 64'd1;
    return (len >= 64) ? '1 : ((one << len) - 64'd1);
  endfunction

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    tdo_log.delete();
  endtask

  task automatic wait_ready(output int cyc, output logic saw_rsp);
    cyc = 0;
    saw_rsp = 1'b0;
    while (!cmd_ready && cyc < 400) begin
      @(posedge CK); #1;
      cyc++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tclk"}, 128'(TCLK), 128'(0));
    chk({tag, "_tms"}, 128'(TMS), 128'(1));
    chk({tag, "_tdi"}, 128'(TDI), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_ready"}, 128'(cmd_ready), 128'(0));
    chk({tag, "_rspv"}, 128'(rsp_valid), 128'(0));
    chk({tag, "_rspe"}, 128'(rsp_err), 128'(0));
    chk({tag, "_rspd"}, 128'(rsp_tdo), 128'(0));
  endtask

  // After TRST release: 6 TCKs, TMS 1,1,1,1,1,0, then ready at 24 CK.
  task automatic check_tlr(input string tag);
    int   cyc;
    logic saw;
    wait_ready(cyc, saw);
    chk({tag, "_cycles"}, 128'(cyc), 128'(6 * 2 * CLK_DIV));
    chk({tag, "_ntck"}, 128'(tms_log.size()), 128'(6));
    chk({tag, "_tms"}, pack(tms_log), 128'h1F);
    chk({tag, "_norsp"}, 128'(saw), 128'(0));
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic send(input logic ir, input int len, input logic [63:0] tdi, output int waitc);
    logic acc;
    logic ok = 1'b0;
    waitc = -1;
    cmd_ir  = ir;
    cmd_len = LEN_W'(len);
    cmd_tdi = tdi;
    clear_logs();
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      acc = cmd_ready;
      @(posedge CK); #1;
      if (acc) begin
        ok = 1'b1;
        waitc = i;
        break;
      end
    end
    cmd_valid = 1'b0;
    chk("accept", 128'(ok), 128'(1));
  endtask

  task automatic expect_rsp(input logic ir, input int len, input logic [63:0] tdi,
                            output logic [63:0] exp_tdo);
    int cyc;
    int off;
    logic [127:0] e_tms;
    exp_tdo = '0;
    if (len == 0 || len > 64) begin
      chk("bad_valid", 128'(rsp_valid), 128'(1));
      chk("bad_err", 128'(rsp_err), 128'(1));
      chk("bad_tdo", 128'(rsp_tdo), 128'(0));
      chk("bad_busy", 128'(busy), 128'(0));
      repeat (6) @(posedge CK);
      #1;
      chk("bad_no_tclk", 128'(tms_log.size()), 128'(0));
      chk("bad_hold", 128'(rsp_valid), 128'(1));
    end else begin
      cyc = 0;
      while (!rsp_valid && cyc < 2000) begin
        @(posedge CK); #1;
        cyc++;
      end
      chk("rsp_arrives", 128'(rsp_valid), 128'(1));
      off = ir ? 4 : 3;
      e_tms = '0;
      e_tms[0] = 1'b1;
      if (ir) e_tms[1] = 1'b1;
      e_tms[off + len - 1] = 1'b1;
      e_tms[off + len] = 1'b1;
      case (tdo_mode)
        0: for (int i = 0; i < len; i++)
             if (off + i < tdo_log.size()) exp_tdo[i] = tdo_log[off + i];
        1: exp_tdo = len_mask(len);
        default: exp_tdo = (tdi << 1) & len_mask(len);
      endcase
      chk("n_tck", 128'(tms_log.size()), 128'(len + off + 2));
      chk("tms_seq", pack(tms_log), e_tms);
      chk("tdi_seq", pack(tdi_log), 128'(tdi & len_mask(len)) << off);
      chk("rsp_tdo", 128'(rsp_tdo), 128'(exp_tdo));
      chk("rsp_err", 128'(rsp_err), 128'(0));
      chk("done_busy", 128'(busy), 128'(0));
      chk("done_pins", {126'd0, TCLK, TMS}, 128'(0));
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge CK); #1;
    rsp_ready = 1'b0;
    chk("rsp_clear", 128'(rsp_valid), 128'(0));
    chk("ready_back", 128'(cmd_ready), 128'(1));
  endtask

  task automatic scan(input logic ir, input int len, input logic [63:0] tdi);
    int w;
    logic [63:0] e;
    send(ir, len, tdi, w);
    expect_rsp(ir, len, tdi, e);
    release_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          cyc;
    logic [63:0] e;
    logic [63:0] r;

    TRST = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    check_reset_values("por");
    clear_logs();
    TRST = 1'b0;
    check_tlr("por_tlr");

    // Single-cycle TRST pulse from idle.
    TRST = 1'b1;
    @(posedge CK); #1;
    check_reset_values("pulse");
    clear_logs();
    TRST = 1'b0;
    check_tlr("pulse_tlr");

    tdo_mode = 2;
    scan(1'b0, 8, 64'hA5);
    tdo_mode = 1;
    scan(1'b1, 2, 64'h3);
    tdo_mode = 0;
    scan(1'b0, 0, 64'hFFFF);
    scan(1'b0, 65, 64'h1234);
    scan(1'b1, 64, {$urandom, $urandom});
    scan(1'b0, 1, 64'h1);

    // Response held: no accept while pending, accept on the edge after the handshake.
    r = {$urandom, $urandom};
    send(1'b1, 12, r, w);
    expect_rsp(1'b1, 12, r, e);
    cmd_ir = 1'b0; cmd_len = LEN_W'(5); cmd_tdi = 64'h15;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CK); #1;
      chk("hold_ready", 128'(cmd_ready), 128'(0));
      chk("hold_valid", 128'(rsp_valid), 128'(1));
      chk("hold_tdo", 128'(rsp_tdo), 128'(e));
    end
    release_rsp();
    send(1'b0, 5, 64'h15, w);
    chk("accept_delay", 128'(w), 128'(0));
    chk("accept_busy", 128'(busy), 128'(1));
    expect_rsp(1'b0, 5, 64'h15, e);
    release_rsp();

    // TRST during the 4th shift TCK of a 16-bit DR scan.
    r = {$urandom, $urandom};
    send(1'b0, 16, r, w);
    cyc = 0;
    while (tms_log.size() < 7 && cyc < 200) begin
      @(posedge CK); #2;
      cyc++;
    end
    chk("abort_reached", 128'(tms_log.size() >= 7), 128'(1));
    TRST = 1'b1;
    @(posedge CK); #1;
    check_reset_values("abort");
    clear_logs();
    TRST = 1'b0;
    check_tlr("abort_tlr");

    for (int n = 0; n < 16; n++) begin
      int   len;
      int   sel;
      logic ir;
      ir  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) len = 0;
      else if (sel == 1) len = int'($urandom_range(65, 127));
      else len = int'($urandom_range(1, 64));
      tdo_mode = int'($urandom_range(0, 2));
      scan(ir, len, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
